// File: rtl/dram_cmd_arbiter.sv
// Single-rank DRAM command arbiter: round-robin over per-bank FSM requests, enforcing tRCD and tCCD_S/tCCD_L.
// Optional stall statistics counter enabled by defining CCD_STATS_EN.
module dram_cmd_arbiter #(
  parameter int NUMBANK      = 4,
  parameter int NUMBANKGROUP = 4,
  parameter int tRCD         = 16,
  parameter int tCCD_S       = 4,
  parameter int tCCD_L       = 6
`ifdef CCD_STATS_EN
  , parameter int STATWIDTH  = 16
`endif
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUMBANK*NUMBANKGROUP-1:0]       req_valid,
  input  logic [3*NUMBANK*NUMBANKGROUP-1:0]     req_cmd,
  output logic [NUMBANK*NUMBANKGROUP-1:0]       grant,
  output logic                                  cmd_valid,
  output logic [2:0]                            cmd_type,
  output logic [$clog2(NUMBANKGROUP)-1:0]       cmd_bg,
  output logic [$clog2(NUMBANK)-1:0]            cmd_bk
`ifdef CCD_STATS_EN
  , output logic [STATWIDTH-1:0]                ccd_stall_cnt
`endif
);

  localparam int NUM_BANKFSM = NUMBANK * NUMBANKGROUP;
  localparam int IDX_W       = $clog2(NUM_BANKFSM);
  localparam int BG_W        = $clog2(NUMBANKGROUP);
  localparam int BK_W        = $clog2(NUMBANK);
  localparam int CNT_MAX     = (tRCD > tCCD_L) ? tRCD : tCCD_L;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);

  // A counter cleared on the grant edge reads k-1 in the k-th cycle after the grant.
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] RCD_MIN  = CNT_W'(tRCD - 1);
  localparam logic [CNT_W-1:0] CCDS_MIN = CNT_W'(tCCD_S - 1);
  localparam logic [CNT_W-1:0] CCDL_MIN = CNT_W'(tCCD_L - 1);

  localparam logic [2:0] CMD_IDLE      = 3'd0;
  localparam logic [2:0] CMD_ACTIVATE  = 3'd1;
  localparam logic [2:0] CMD_READ      = 3'd2;
  localparam logic [2:0] CMD_AUTOREAD  = 3'd3;
  localparam logic [2:0] CMD_WRITE     = 3'd4;
  localparam logic [2:0] CMD_AUTOWRITE = 3'd5;

  logic [CNT_W-1:0]       act_cnt [NUM_BANKFSM];
  logic [CNT_W-1:0]       col_cnt;
  logic [BG_W-1:0]        col_bg;
  logic [IDX_W-1:0]       rr_ptr;
  logic [NUM_BANKFSM-1:0] eligible;
  logic                   found;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       sel;
  logic [2:0]             win_cmd;
  logic                   win_col;
  logic [BG_W-1:0]        win_bg;
  logic [BK_W-1:0]        win_bk;

  function automatic logic is_col(input logic [2:0] c);
    return (c == CMD_READ) || (c == CMD_AUTOREAD) || (c == CMD_WRITE) || (c == CMD_AUTOWRITE);
  endfunction

`ifdef CCD_STATS_EN
  logic [NUM_BANKFSM-1:0] ccd_block;
`endif

  for (genvar i = 0; i < NUM_BANKFSM; i++) begin : g_elig
    logic [2:0] c;
    logic       col, rcd_ok, ccd_ok, same_bg;
    assign c       = req_cmd[3*i +: 3];
    assign col     = is_col(c);
    assign same_bg = (col_bg == BG_W'(i / NUMBANK));
    assign rcd_ok  = (act_cnt[i] >= RCD_MIN);
    assign ccd_ok  = same_bg ? (col_cnt >= CCDL_MIN) : (col_cnt >= CCDS_MIN);
    assign eligible[i] = req_valid[i] && (c != CMD_IDLE) && (!col || (rcd_ok && ccd_ok));
`ifdef CCD_STATS_EN
    assign ccd_block[i] = req_valid[i] && col && rcd_ok && !ccd_ok;
`endif
  end

  // First eligible requester at or after the round-robin pointer wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sel    = '0;
    for (int k = 0; k < NUM_BANKFSM; k++) begin
      sel = IDX_W'((int'(rr_ptr) + k) % NUM_BANKFSM);
      if (!found && eligible[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  always_comb begin
    win_cmd = req_cmd[int'(winner)*3 +: 3];
    win_col = is_col(win_cmd);
    win_bg  = BG_W'(int'(winner) / NUMBANK);
    win_bk  = BK_W'(int'(winner) % NUMBANK);
    grant   = '0;
    if (found && !rst) grant[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKFSM; i++) act_cnt[i] <= CNT_SAT;
      col_cnt   <= CNT_SAT;
      col_bg    <= '0;
      rr_ptr    <= '0;
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_IDLE;
      cmd_bg    <= '0;
      cmd_bk    <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKFSM; i++) begin
        if (found && (winner == IDX_W'(i)) && (win_cmd == CMD_ACTIVATE)) act_cnt[i] <= '0;
        else if (act_cnt[i] != CNT_SAT) act_cnt[i] <= act_cnt[i] + CNT_W'(1);
      end
      if (found && win_col) begin
        col_cnt <= '0;
        col_bg  <= win_bg;
      end else if (col_cnt != CNT_SAT) begin
        col_cnt <= col_cnt + CNT_W'(1);
      end
      if (found) rr_ptr <= (winner == IDX_W'(NUM_BANKFSM - 1)) ? '0 : winner + IDX_W'(1);
      cmd_valid <= found;
      cmd_type  <= found ? win_cmd : CMD_IDLE;
      cmd_bg    <= found ? win_bg : '0;
      cmd_bk    <= found ? win_bk : '0;
    end
  end

`ifdef CCD_STATS_EN
  // Counts cycles where some column request had tRCD satisfied but was held off by tCCD.
  always_ff @(posedge clk) begin
    if (rst) ccd_stall_cnt <= '0;
    else if ((|ccd_block) && (ccd_stall_cnt != '1)) ccd_stall_cnt <= ccd_stall_cnt + STATWIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// Directed testbench for dram_cmd_arbiter: reset, tRCD, tCCD_S/L, round-robin sweep, mixed-command bypass, mid-run reset.
module tb_dram_cmd_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] req_valid;
  logic [47:0] req_cmd;
  logic [15:0] grant;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [1:0]  cmd_bg;
  logic [1:0]  cmd_bk;
`ifdef CCD_STATS_EN
  logic [15:0] ccd_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dram_cmd_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .grant     (grant),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_bg    (cmd_bg),
    .cmd_bk    (cmd_bk)
`ifdef CCD_STATS_EN
    , .ccd_stall_cnt (ccd_stall_cnt)
`endif
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks; inputs change on the falling edge, checks follow 1 time unit later.
  task automatic clr_req();
    req_valid = '0;
    req_cmd   = '0;
  endtask

  task automatic set_req(input int i, input logic [2:0] c);
    req_valid[i]     = 1'b1;
    req_cmd[3*i +: 3] = c;
  endtask

  task automatic drop_req(input int i);
    req_valid[i]      = 1'b0;
    req_cmd[3*i +: 3] = 3'd0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_req();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr_req();

    // Reset state, request ignored while rst high
    next_cycle();
    next_cycle();
    set_req(0, 3'd1);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_type", 32'(cmd_type), 32'd0);
    chk("rst_cmd_bg", 32'(cmd_bg), 32'd0);
    chk("rst_cmd_bk", 32'(cmd_bk), 32'd0);
`ifdef CCD_STATS_EN
    chk("rst_stall", 32'(ccd_stall_cnt), 32'd0);
`endif

    // ACTIVATE FSM0 at cycle 0, registered at cycle 1
    next_cycle();
    rst = 1'b0;
    #1;
    chk("act0_grant_c0", 32'(grant), 32'h0001);
    next_cycle();
    drop_req(0);
    #1;
    chk("act0_valid_c1", 32'(cmd_valid), 32'd1);
    chk("act0_type_c1", 32'(cmd_type), 32'd1);
    chk("act0_bg_c1", 32'(cmd_bg), 32'd0);
    chk("act0_bk_c1", 32'(cmd_bk), 32'd0);
    chk("act0_grant_c1", 32'(grant), 32'h0);
    next_cycle();
    #1;
    chk("idle_valid_c2", 32'(cmd_valid), 32'd0);
    chk("idle_type_c2", 32'(cmd_type), 32'd0);

    // tRCD: ACT FSM5 cycle 0, READ FSM5 from cycle 1 -> granted cycle 16
    do_reset();
    set_req(5, 3'd1);
    #1;
    chk("rcd_act_grant", 32'(grant), 32'h0020);
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      if (c == 1) set_req(5, 3'd2);
      #1;
      if (c == 1) begin
        chk("rcd_act_type", 32'(cmd_type), 32'd1);
        chk("rcd_act_bg", 32'(cmd_bg), 32'd1);
        chk("rcd_act_bk", 32'(cmd_bk), 32'd1);
      end
      chk($sformatf("rcd_grant_c%0d", c), 32'(grant), (c == 16) ? 32'h0020 : 32'h0);
    end
    next_cycle();
    drop_req(5);
    #1;
    chk("rcd_rd_valid", 32'(cmd_valid), 32'd1);
    chk("rcd_rd_type", 32'(cmd_type), 32'd2);
    chk("rcd_rd_bg", 32'(cmd_bg), 32'd1);
    chk("rcd_rd_bk", 32'(cmd_bk), 32'd1);

    // tCCD_L: READ FSM0 cycle 0, READ FSM1 (same BG) -> cycle 6
    do_reset();
    set_req(0, 3'd2);
    #1;
    chk("ccdl_rd0_grant", 32'(grant), 32'h0001);
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c == 1) begin
        drop_req(0);
        set_req(1, 3'd2);
      end
      #1;
      chk($sformatf("ccdl_grant_c%0d", c), 32'(grant), (c == 6) ? 32'h0002 : 32'h0);
    end

    // tCCD_S: READ FSM0 cycle 0, WRITE FSM4 (other BG) -> cycle 4
    do_reset();
    set_req(0, 3'd2);
    #1;
    chk("ccds_rd0_grant", 32'(grant), 32'h0001);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 1) begin
        drop_req(0);
        set_req(4, 3'd4);
      end
      #1;
      chk($sformatf("ccds_grant_c%0d", c), 32'(grant), (c == 4) ? 32'h0010 : 32'h0);
    end

    // Round-robin sweep: all 16 PRECHARGE, plus an IDLE-valid check first
    do_reset();
    set_req(3, 3'd0);
    #1;
    chk("idle_req_ignored", 32'(grant), 32'h0);
    for (int i = 0; i < 16; i++) set_req(i, 3'd6);
    #1;
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) begin
        next_cycle();
        #1;
        chk($sformatf("rr_bg_c%0d", c), 32'(cmd_bg), 32'(((c - 1) % 16) / 4));
        chk($sformatf("rr_bk_c%0d", c), 32'(cmd_bk), 32'((c - 1) % 4));
        chk($sformatf("rr_type_c%0d", c), 32'(cmd_type), 32'd6);
      end
      chk($sformatf("rr_grant_c%0d", c), 32'(grant), 32'(16'h0001 << (c % 16)));
    end

    // Blocked READ FSM1 skipped in favour of ACTIVATE FSM2
    do_reset();
    set_req(0, 3'd2);
    #1;
    chk("skip_rd0_grant", 32'(grant), 32'h0001);
    next_cycle();
    drop_req(0);
    set_req(1, 3'd2);
    set_req(2, 3'd1);
    #1;
    chk("skip_grant", 32'(grant), 32'h0004);
    next_cycle();
    drop_req(2);
    #1;
    chk("skip_type", 32'(cmd_type), 32'd1);
    chk("skip_bk", 32'(cmd_bk), 32'd2);
`ifdef CCD_STATS_EN
    chk("skip_stall", 32'(ccd_stall_cnt), 32'd1);
`endif

    // Mid-run reset discards column history
    do_reset();
    set_req(0, 3'd2);
    #1;
    chk("mrst_rd0_grant", 32'(grant), 32'h0001);
    next_cycle();
    drop_req(0);
    set_req(1, 3'd2);
    rst = 1'b1;
    #1;
    chk("mrst_grant_in_rst", 32'(grant), 32'h0);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("mrst_grant_after", 32'(grant), 32'h0002);
    chk("mrst_cmd_valid", 32'(cmd_valid), 32'd0);
`ifdef CCD_STATS_EN
    chk("mrst_stall", 32'(ccd_stall_cnt), 32'd0);
`endif
    next_cycle();
    clr_req();
    #1;
    chk("mrst_rd1_type", 32'(cmd_type), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
